egress_scheduler: RTL and testbench

Downstream consumer of the transfer layer's four output-port FIFOs (P0–P3). Drains non-empty ports with a round-robin pop scheduler and merges their 12-bit words into one output stream with stall backpressure. Keeps a per-port pop counter that can be read back with a `req`/`idx` query. It follows the reset-then-`init` bring-up sequence used by the rest of the transfer layer.

---
 rtl/egress_scheduler.sv | 177 +++++++++++++++++
 tb/tb_egress_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/egress_scheduler.sv
// egress_scheduler: drains four output-port FIFOs (P0..P3) with a round-robin
// pop scheduler and merges their words into one stalled output stream.
// A per-port pop counter can be read back with a req/idx query.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   init                one-cycle pulse: clear counters, pointer to 3
//   emptyP0..3          port FIFO empty flags
//   dataOutputP0..3     port FIFO read data, sampled at the pop edge
//   popOutP0..3         pop strobes (combinational, one-hot or zero)
//   stall               downstream backpressure
//   dataOut/validOut/srcPort   merged output word, valid flag and source port
//   req/idx             counter query strobe and index
//   counterOut/counterValid    query result, valid one cycle after req
//   state               IDLE=0, INIT=1, ACTIVE=2
module egress_scheduler #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              emptyP0,
  input  logic              emptyP1,
  input  logic              emptyP2,
  input  logic              emptyP3,
  input  logic [DATA_W-1:0] dataOutputP0,
  input  logic [DATA_W-1:0] dataOutputP1,
  input  logic [DATA_W-1:0] dataOutputP2,
  input  logic [DATA_W-1:0] dataOutputP3,
  output logic              popOutP0,
  output logic              popOutP1,
  output logic              popOutP2,
  output logic              popOutP3,
  input  logic              stall,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut,
  output logic [1:0]        srcPort,
  input  logic              req,
  input  logic [2:0]        idx,
  output logic [CNT_W-1:0]  counterOut,
  output logic              counterValid,
  output logic [1:0]        state
);

  localparam int unsigned NPORT = 4;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_INIT   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q [NPORT];
  logic [CNT_W-1:0]  cnt_d [NPORT];
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [1:0]        src_q, src_d;
  logic [CNT_W-1:0]  cnt_out_q, cnt_out_d;
  logic              cnt_valid_q, cnt_valid_d;

  logic [3:0]        empty_vec;
  logic [DATA_W-1:0] port_data [NPORT];
  logic              any_ready;
  logic [1:0]        sel;
  logic [1:0]        cand;
  logic [3:0]        pop_vec;
  logic              pop_en;

  assign empty_vec    = {emptyP3, emptyP2, emptyP1, emptyP0};
  assign port_data[0] = dataOutputP0;
  assign port_data[1] = dataOutputP1;
  assign port_data[2] = dataOutputP2;
  assign port_data[3] = dataOutputP3;

  // Round-robin search: ptr+1, ptr+2, ptr+3, ptr; first non-empty port wins.
  always_comb begin
    any_ready = 1'b0;
    sel       = ptr_q;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!any_ready && !empty_vec[cand]) begin
        any_ready = 1'b1;
        sel       = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (init) state_d = S_INIT;
      S_INIT:   state_d = S_ACTIVE;
      S_ACTIVE: if (init) state_d = S_INIT;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM output: pop strobe. A stalled valid word blocks pops, so a pop always
  // coincides with the current word leaving (or there being none).
  always_comb begin
    pop_vec = 4'b0000;
    pop_en  = 1'b0;
    if (!reset && state_q == S_ACTIVE && !init && !stall && any_ready) begin
      pop_en       = 1'b1;
      pop_vec[sel] = 1'b1;
    end
  end

  assign popOutP0 = pop_vec[0];
  assign popOutP1 = pop_vec[1];
  assign popOutP2 = pop_vec[2];
  assign popOutP3 = pop_vec[3];

  // Datapath next values: output stage, pointer, counters, query.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    for (int p = 0; p < NPORT; p++) cnt_d[p] = cnt_q[p];

    if (valid_q && !stall) valid_d = 1'b0;
    if (pop_en) begin
      valid_d    = 1'b1;
      data_d     = port_data[sel];
      src_d      = sel;
      ptr_d      = sel;
      cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
    end

    if (state_q == S_INIT) begin
      ptr_d = 2'd3;
      for (int p = 0; p < NPORT; p++) cnt_d[p] = '0;
    end

    // Query reads the pre-increment / pre-clear counter value.
    cnt_valid_d = req;
    cnt_out_d   = '0;
    if (req && !idx[2]) cnt_out_d = cnt_q[idx[1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= 2'd3;
      data_q      <= '0;
      valid_q     <= 1'b0;
      src_q       <= 2'd0;
      cnt_out_q   <= '0;
      cnt_valid_q <= 1'b0;
      for (int p = 0; p < NPORT; p++) cnt_q[p] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      src_q       <= src_d;
      cnt_out_q   <= cnt_out_d;
      cnt_valid_q <= cnt_valid_d;
      for (int p = 0; p < NPORT; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign dataOut      = data_q;
  assign validOut     = valid_q;
  assign srcPort      = src_q;
  assign counterOut   = cnt_out_q;
  assign counterValid = cnt_valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_egress_scheduler.sv
// Directed bench for egress_scheduler: bring-up, round-robin, sparse ports,
// backpressure, init mid-stream, counter wrap/query and reset-over-init.
module tb_egress_scheduler;

  logic        clk = 1'b0;
  logic        reset, init, stall, req;
  logic [2:0]  idx;
  logic [3:0]  emp;
  logic [11:0] dp [4];
  logic        popOutP0, popOutP1, popOutP2, popOutP3;
  logic [11:0] dataOut;
  logic        validOut, counterValid;
  logic [1:0]  srcPort, state;
  logic [4:0]  counterOut;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  egress_scheduler #(.DATA_W(12), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .init(init),
    .emptyP0(emp[0]), .emptyP1(emp[1]), .emptyP2(emp[2]), .emptyP3(emp[3]),
    .dataOutputP0(dp[0]), .dataOutputP1(dp[1]),
    .dataOutputP2(dp[2]), .dataOutputP3(dp[3]),
    .popOutP0(popOutP0), .popOutP1(popOutP1),
    .popOutP2(popOutP2), .popOutP3(popOutP3),
    .stall(stall), .dataOut(dataOut), .validOut(validOut), .srcPort(srcPort),
    .req(req), .idx(idx), .counterOut(counterOut),
    .counterValid(counterValid), .state(state)
  );

  function automatic logic [3:0] pops();
    return {popOutP3, popOutP2, popOutP1, popOutP0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs then change and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    dp[0] = 12'hA10; dp[1] = 12'hB21; dp[2] = 12'hC32; dp[3] = 12'hD43;
    reset = 1'b1; init = 1'b0; stall = 1'b0; req = 1'b0; idx = 3'd0;
    emp = 4'b0000;

    // Bring-up: outputs zero in reset, no pops in IDLE.
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(validOut), 32'd0);
    chk("rst_data", 32'(dataOut), 32'd0);
    chk("rst_src", 32'(srcPort), 32'd0);
    chk("rst_cntv", 32'(counterValid), 32'd0);
    chk("rst_cnt", 32'(counterOut), 32'd0);
    chk("rst_pop", 32'(pops()), 32'd0);
    reset = 1'b0;
    step();
    settle();
    chk("idle_pop", 32'(pops()), 32'd0);
    step();
    init = 1'b1;
    settle();
    chk("idle_init_pop", 32'(pops()), 32'd0);
    step();
    init = 1'b0;
    settle();
    chk("init_state", 32'(state), 32'd1);
    chk("init_pop", 32'(pops()), 32'd0);
    step();
    chk("active_state", 32'(state), 32'd2);

    // Round-robin with all ports non-empty: P0,P1,P2,P3,P0.
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("rr_pop%0d", i), 32'(pops()), 32'(4'b0001 << (i % 4)));
      step();
      chk($sformatf("rr_valid%0d", i), 32'(validOut), 32'd1);
      chk($sformatf("rr_src%0d", i), 32'(srcPort), 32'(i % 4));
      chk($sformatf("rr_data%0d", i), 32'(dataOut), 32'(dp[i % 4]));
    end

    // Query in the same cycle as a P1 pop returns the pre-increment value (1).
    req = 1'b1; idx = 3'd1;
    settle();
    chk("q_pop_p1", 32'(pops()), 32'b0010);
    step();
    req = 1'b0;
    emp = 4'b1111;
    settle();
    chk("q_pre_inc_v", 32'(counterValid), 32'd1);
    chk("q_pre_inc", 32'(counterOut), 32'd1);
    chk("drain_pop", 32'(pops()), 32'd0);
    step();
    chk("q_pulse", 32'(counterValid), 32'd0);
    chk("drain_valid", 32'(validOut), 32'd0);

    // Sparse ports (ptr=1): P2, then P1 appears -> P2,P1,P2,P2.
    emp = 4'b1011; settle(); chk("sp_pop0", 32'(pops()), 32'b0100);
    step(); chk("sp_src0", 32'(srcPort), 32'd2);
    emp = 4'b1001; settle(); chk("sp_pop1", 32'(pops()), 32'b0010);
    step(); chk("sp_src1", 32'(srcPort), 32'd1);
    emp = 4'b1011; settle(); chk("sp_pop2", 32'(pops()), 32'b0100);
    step(); chk("sp_src2", 32'(srcPort), 32'd2);
    settle(); chk("sp_pop3", 32'(pops()), 32'b0100);
    step(); chk("sp_src3", 32'(srcPort), 32'd2);

    // Backpressure: P1 pop, then stall for 3 cycles with all ports non-empty.
    emp = 4'b1101; settle(); chk("bp_pop_p1", 32'(pops()), 32'b0010);
    step();
    emp = 4'b0000;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("bp_pop%0d", i), 32'(pops()), 32'd0);
      chk($sformatf("bp_valid%0d", i), 32'(validOut), 32'd1);
      chk($sformatf("bp_src%0d", i), 32'(srcPort), 32'd1);
      chk($sformatf("bp_data%0d", i), 32'(dataOut), 32'(dp[1]));
      step();
    end
    stall = 1'b0;
    settle();
    chk("bp_resume_pop", 32'(pops()), 32'b0100);
    chk("bp_resume_src", 32'(srcPort), 32'd1);
    step();
    chk("bp_next_src", 32'(srcPort), 32'd2);

    // init mid-stream: P0 word survives, no pop in the init cycle.
    emp = 4'b1110; settle(); chk("ini_pop_p0", 32'(pops()), 32'b0001);
    step();
    emp = 4'b0000;
    init = 1'b1;
    settle();
    chk("ini_nopop", 32'(pops()), 32'd0);
    chk("ini_valid", 32'(validOut), 32'd1);
    chk("ini_src", 32'(srcPort), 32'd0);
    chk("ini_data", 32'(dataOut), 32'(dp[0]));
    step();
    init = 1'b0;
    req = 1'b1; idx = 3'd2;
    settle();
    chk("ini_state", 32'(state), 32'd1);
    chk("ini_valid_after", 32'(validOut), 32'd0);
    chk("ini_init_pop", 32'(pops()), 32'd0);
    step();
    // P2 count before clear: 1 (round robin) + 3 (sparse) + 1 (resume) = 5.
    idx = 3'd0;
    settle();
    chk("ini_preclear_v", 32'(counterValid), 32'd1);
    chk("ini_preclear", 32'(counterOut), 32'd5);
    chk("ini_first_pop", 32'(pops()), 32'b0001);
    step();
    req = 1'b0;
    chk("ini_cleared", 32'(counterOut), 32'd0);
    chk("ini_first_src", 32'(srcPort), 32'd0);

    // 33 pops from P3 after clear -> counter wraps to 1.
    emp = 4'b0111;
    for (int i = 0; i < 33; i++) begin
      settle();
      chk($sformatf("wrap_pop%0d", i), 32'(pops()), 32'b1000);
      step();
    end
    emp = 4'b1111;
    req = 1'b1; idx = 3'd3;
    step();
    chk("wrap_v", 32'(counterValid), 32'd1);
    chk("wrap_val", 32'(counterOut), 32'd1);
    idx = 3'd5;
    step();
    chk("idx5_v", 32'(counterValid), 32'd1);
    chk("idx5_val", 32'(counterOut), 32'd0);
    req = 1'b0;
    step();
    chk("q_end_pulse", 32'(counterValid), 32'd0);

    // Reset and init together in ACTIVE: reset wins, no pop.
    emp = 4'b0111;
    reset = 1'b1; init = 1'b1;
    settle();
    chk("rst_init_pop", 32'(pops()), 32'd0);
    step();
    chk("rst_init_state", 32'(state), 32'd0);
    chk("rst_init_valid", 32'(validOut), 32'd0);
    reset = 1'b0; init = 1'b0;
    step();
    chk("rst_idle_state", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
